// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: next-PC generation and instruction-fetch front end.
// Owns the fetch PC, issues one imem request at a time over valid/ready,
// and buffers the returned word in a one-entry IF/ID slot. Redirects and
// exception entry flush younger work; misaligned targets become a marker
// entry for decode rather than a memory request.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   imem_req_valid/addr/ready         fetch request handshake (addr = fetch PC)
//   imem_resp_valid/data              instruction word return
//   if_valid/pc/instr/exc, if_ready   IF/ID slot towards decode
//   redir_valid/op/cond/pc/bimm/jimm/ra, epc   decode-stage control transfer
//   exc_req                           exception entry (wins over redir_valid)
// AW must be at least 29 so the j/jal region bits [AW-1:28] exist.
module pc_fetch_unit #(
    parameter int unsigned   AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(32'h0000_3000),
    parameter logic [AW-1:0] EXC_VEC  = AW'(32'h0000_4180)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          imem_req_valid,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_req_ready,
    input  logic          imem_resp_valid,
    input  logic [31:0]   imem_resp_data,
    output logic          if_valid,
    output logic [AW-1:0] if_pc,
    output logic [31:0]   if_instr,
    output logic          if_exc,
    input  logic          if_ready,
    input  logic          redir_valid,
    input  logic [1:0]    redir_op,
    input  logic          redir_cond,
    input  logic [AW-1:0] redir_pc,
    input  logic [AW-1:0] redir_bimm,
    input  logic [25:0]   redir_jimm,
    input  logic [AW-1:0] redir_ra,
    input  logic [AW-1:0] epc,
    input  logic          exc_req
);

    localparam int unsigned IW = 32;

    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_BLOCK = 2'd2;

    localparam logic [1:0] OP_BR   = 2'd0;
    localparam logic [1:0] OP_J    = 2'd1;
    localparam logic [1:0] OP_JR   = 2'd2;

    logic [1:0]    state_q,    state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] req_pc_q,   req_pc_d;
    logic          kill_q,     kill_d;
    logic          if_valid_q, if_valid_d;
    logic [AW-1:0] if_pc_q,    if_pc_d;
    logic [IW-1:0] if_instr_q, if_instr_d;
    logic          if_exc_q,   if_exc_d;

    logic          redirect;
    logic [AW-1:0] redir_target;
    logic          buf_free;
    logic          pc_aligned;

    // A not-taken branch is not a redirect; exception entry always is.
    assign redirect   = exc_req |
                        (redir_valid & ~((redir_op == OP_BR) & ~redir_cond));
    assign buf_free   = ~if_valid_q | if_ready;
    assign pc_aligned = (fetch_pc_q[1:0] == 2'b00);

    // Redirect target selection, exception first.
    always_comb begin
        redir_target = epc;
        if (exc_req) begin
            redir_target = EXC_VEC;
        end else begin
            case (redir_op)
                OP_BR:   redir_target = redir_pc + AW'(4) + redir_bimm;
                OP_J:    redir_target = {redir_pc[AW-1:28], redir_jimm, 2'b00};
                OP_JR:   redir_target = redir_ra;
                default: redir_target = epc;
            endcase
        end
    end

    // Request is combinational so a redirect can suppress it in the same cycle.
    assign imem_req_valid = (state_q == ST_REQ) & buf_free & pc_aligned & ~redirect;
    assign imem_req_addr  = fetch_pc_q;

    // Next-state, fetch PC and IF/ID slot update.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        kill_d     = kill_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_exc_d   = if_exc_q;

        if (if_valid_q && if_ready) begin
            if_valid_d = 1'b0;
        end

        case (state_q)
            ST_REQ: begin
                if (!redirect && buf_free) begin
                    if (!pc_aligned) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = fetch_pc_q;
                        if_instr_d = '0;
                        if_exc_d   = 1'b1;
                        state_d    = ST_BLOCK;
                    end else if (imem_req_ready) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + AW'(4);
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    // Killed or same-cycle-redirected words are dropped.
                    if (!kill_q && !redirect) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = req_pc_q;
                        if_instr_d = imem_resp_data;
                        if_exc_d   = 1'b0;
                    end
                    kill_d  = 1'b0;
                    state_d = ST_REQ;
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            ST_BLOCK: begin
                if (redirect) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // Redirect wins over any slot load or consumption this cycle.
        if (redirect) begin
            fetch_pc_d = redir_target;
            if_valid_d = 1'b0;
            if_pc_d    = '0;
            if_instr_d = '0;
            if_exc_d   = 1'b0;
        end
    end

    // State and slot registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            if_exc_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            kill_q     <= kill_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_exc_q   <= if_exc_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;
    assign if_exc   = if_exc_q;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised next-PC generation and instruction-fetch front end for the pipelined MIPS core. It owns the architectural fetch PC register, issues one instruction-memory request at a time over a valid/ready handshake, and buffers the returned word in a one-entry IF/ID slot. Redirects from decode (branch, `j`/`jal`, `jr`/`jalr`, `eret`) and exception entry flush younger fetches. Misaligned fetch targets are flagged to decode instead of being sent to memory.

## Interface
- `AW`, 32 — PC/address width; must be ≥ 29.
- `RESET_PC`, 32'h0000_3000 — fetch address after reset.
- `EXC_VEC`, 32'h0000_4180 — exception entry address.
- `clk` in 1 — single clock, rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `imem_req_valid` out 1 — fetch request.
- `imem_req_addr` out AW — word address of the request; equals `fetch_pc`.
- `imem_req_ready` in 1 — memory accepts the request.
- `imem_resp_valid` in 1 — response word valid.
- `imem_resp_data` in 32 — instruction word.
- `if_valid` out 1 — IF/ID slot holds an entry.
- `if_pc` out AW — PC of the entry.
- `if_instr` out 32 — instruction of the entry.
- `if_exc` out 1 — entry is a misaligned-fetch marker.
- `if_ready` in 1 — decode consumes the entry this cycle.
- `redir_valid` in 1 — decode-stage control transfer.
- `redir_op` in 2 — 0 = branch, 1 = j/jal, 2 = jr/jalr, 3 = eret.
- `redir_cond` in 1 — branch outcome; used only when op = 0.
- `redir_pc` in AW — PC of the redirecting instruction.
- `redir_bimm` in AW — sign-extended branch offset, already shifted left by 2.
- `redir_jimm` in 26 — jump index field.
- `redir_ra` in AW — register target.
- `epc` in AW — `eret` target.
- `exc_req` in 1 — exception entry; has priority over `redir_valid`.

## Operation
- **Targets**
  - Branch: `redir_pc + 4 + redir_bimm`, modulo 2^AW.
  - j/jal: `{redir_pc[AW-1:28], redir_jimm, 2'b00}`.
  - jr/jalr: `redir_ra`.
  - eret: `epc`.
  - Exception: `EXC_VEC`.
- **Redirect condition.** A redirect is active when `exc_req`, or when `redir_valid` and not (op = 0 and `redir_cond` = 0). A not-taken branch is a no-op.
- **Flush semantics.** No delay slot. A redirect flushes every younger instruction.
- **On an active redirect, in the same cycle:**
  - `fetch_pc` loads the target.
  - The IF/ID slot is cleared.
  - `imem_req_valid` is forced to 0 combinationally.
  - If state = WAIT and no response arrives this cycle, `kill` is set.
  - A response arriving this cycle is discarded.
- **FSM states:** REQ, WAIT, BLOCK.
- **REQ**
  - `imem_req_valid` = buffer free, and `fetch_pc[1:0]` = 0, and no redirect.
  - Buffer free means `!if_valid`, or `if_valid & if_ready`.
  - On `imem_req_ready`: `req_pc` ← `fetch_pc`, `fetch_pc` ← `fetch_pc + 4`, go to WAIT.
  - If `fetch_pc[1:0]` ≠ 0 and the buffer is free: load the slot with `if_pc` = `fetch_pc`, `if_instr` = 0, `if_exc` = 1, then go to BLOCK.
  - `imem_resp_valid` is ignored in REQ.
- **WAIT**
  - On `imem_resp_valid` with `kill` set: drop the word, clear `kill`, go to REQ.
  - On `imem_resp_valid` with `kill` clear: load the slot (`if_pc` = `req_pc`, `if_instr` = data, `if_exc` = 0), go to REQ.
  - The slot is guaranteed free on arrival because a request is only issued when the buffer is free.
- **BLOCK**
  - No requests are issued.
  - Leave to REQ only on an active redirect.
- **Decode stall.** `if_ready` = 0 holds all slot outputs stable.
- **Simultaneous redirect and consumption.** Redirect wins; the slot is empty next cycle.

## Timing
- **Reset values:** `fetch_pc` = `RESET_PC`, state = REQ, `kill` = 0, `if_valid` = 0, `if_pc` = 0, `if_instr` = 0, `if_exc` = 0.
- `imem_req_valid` and `imem_req_addr` are valid in the first cycle after reset deassertion.
- **Reset mid-transaction:** a stale response after reset arrives in REQ and is ignored.
- **Latency:** request accepted in cycle N → response earliest in N+1 → `if_valid` in N+2.
- **Throughput:** peak one instruction per 2 cycles with a 1-cycle memory.
- **Redirect in cycle N:**
  - `imem_req_addr` = target in cycle N+1 when state is REQ.
  - In WAIT, the target is issued after the killed response returns.
- The first `if_valid` after a redirect is never an older PC.

## Test plan
- **Reset and sequential fetch.** Release reset; memory always ready with a 1-cycle response → requests at 0x3000, 0x3004, 0x3008; `if_valid` pulses with matching `if_pc`/`if_instr`; `if_exc` = 0.
- **Branch redirect with kill.** Taken branch: `redir_pc` = 0x3004, `bimm` = 0x10, asserted while in WAIT → the in-flight response is dropped, the next request is 0x3018, and no `if_pc` = 0x3008 ever appears. A not-taken branch causes no flush.
- **Jump and register targets.**
  - j: `redir_pc` = 0x3000, `jimm` = 0x0000C40 → request 0x3100.
  - jr: `redir_ra` = 0x3050 → request 0x3050.
  - eret: `epc` = 0x3020 → request 0x3020.
- **Decode stall.** `if_ready` = 0 for 5 cycles with an entry held → outputs stable, no new request; release → the next request is issued.
- **Misaligned target.** jr to 0x3052 → no memory request; slot gets `if_pc` = 0x3052, `if_instr` = 0, `if_exc` = 1; unit stays in BLOCK until `exc_req` → request 0x4180.
- **Priority and reset.**
  - `exc_req` together with taken `redir_valid` → target 0x4180.
  - Assert `reset_n` = 0 while in WAIT, then return a response after release → response ignored, request 0x3000.
